// File: rtl/tuser_out_fsm.sv
// Re-attaches the SDNet output tuple to every beat of its packet as tuser.
// Tuples are buffered in a small FIFO; a packet stalls until its tuple is present.
//
// state | meaning
// IDLE  | between packets; a first beat is accepted only once a tuple is buffered
// WRDN  | mid-packet; beats carry the tuple latched at the first beat
module tuser_out_fsm #(
  parameter int TUPLE_DEPTH = 4,
  parameter int CNT_W       = 3
) (
  input  logic               tout_aclk,
  input  logic               tout_arst,
  input  logic               tout_valid,
  input  logic [127:0]       tout_data,
  input  logic               tout_avalid,
  output logic               tout_aready,
  input  logic [255:0]       tout_adata,
  input  logic [31:0]        tout_akeep,
  input  logic               tout_atlast,
  output logic               tout_bvalid,
  input  logic               tout_bready,
  output logic [255:0]       tout_bdata,
  output logic [31:0]        tout_bkeep,
  output logic               tout_btlast,
  output logic [127:0]       tout_btuser,
  output logic [CNT_W-1:0]   tout_tuple_cnt,
  output logic               tout_tuple_ovf
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic {IDLE = 1'b0, WRDN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [127:0]       fifo_q [TUPLE_DEPTH];
  logic [127:0]       fifo_d [TUPLE_DEPTH];
  logic [127:0]       cur_tuple_q, cur_tuple_d;
  logic               ovf_q, ovf_d;
  logic               bvalid_q, bvalid_d;
  logic [255:0]       bdata_q, bdata_d;
  logic [31:0]        bkeep_q, bkeep_d;
  logic               btlast_q, btlast_d;
  logic [127:0]       btuser_q, btuser_d;

  logic               slice_ld;
  logic               accept;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic [127:0]       head;

  assign slice_ld    = !bvalid_q || tout_bready;
  // Gated by reset so aready reads 0 throughout the reset window, not just after the edge.
  assign tout_aready = tout_arst && slice_ld && ((state_q == WRDN) || (cnt_q != '0));
  assign accept      = tout_avalid && tout_aready;
  assign pop         = accept && tout_atlast;
  assign full        = (cnt_q == CNT_W'(TUPLE_DEPTH));
  assign push_ok     = tout_valid && (!full || pop);
  assign head        = fifo_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    cur_tuple_d = cur_tuple_q;
    ovf_d       = ovf_q || (tout_valid && full && !pop);
    bvalid_d    = bvalid_q;
    bdata_d     = bdata_q;
    bkeep_d     = bkeep_q;
    btlast_d    = btlast_q;
    btuser_d    = btuser_q;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = tout_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (slice_ld) begin
      bvalid_d = accept;
      if (accept) begin
        bdata_d  = tout_adata;
        bkeep_d  = tout_akeep;
        btlast_d = tout_atlast;
        btuser_d = (state_q == IDLE) ? head : cur_tuple_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && !tout_atlast) begin
          cur_tuple_d = head;
          state_d     = WRDN;
        end
      end
      WRDN: begin
        if (accept && tout_atlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tout_aclk) begin
    if (!tout_arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < TUPLE_DEPTH; i++) fifo_q[i] <= '0;
      cur_tuple_q <= '0;
      ovf_q       <= 1'b0;
      bvalid_q    <= 1'b0;
      bdata_q     <= '0;
      bkeep_q     <= '0;
      btlast_q    <= 1'b0;
      btuser_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_q      <= fifo_d;
      cur_tuple_q <= cur_tuple_d;
      ovf_q       <= ovf_d;
      bvalid_q    <= bvalid_d;
      bdata_q     <= bdata_d;
      bkeep_q     <= bkeep_d;
      btlast_q    <= btlast_d;
      btuser_q    <= btuser_d;
    end
  end

  assign tout_bvalid    = bvalid_q;
  assign tout_bdata     = bdata_q;
  assign tout_bkeep     = bkeep_q;
  assign tout_btlast    = btlast_q;
  assign tout_btuser    = btuser_q;
  assign tout_tuple_cnt = cnt_q;
  assign tout_tuple_ovf = ovf_q;

endmodule

// File: tb/tb_tuser_out_fsm.sv
// Directed bench for tuser_out_fsm: tuple buffering, tuser re-attachment,
// back-pressure, FIFO overflow and mid-packet reset.
module tb_tuser_out_fsm;

  logic         clk = 1'b0;
  logic         arst, tval, aval, alast, bready;
  logic [127:0] tdat;
  logic [255:0] adat;
  logic [31:0]  akeep;
  logic         aready, bvalid, btlast, ovf;
  logic [255:0] bdata;
  logic [31:0]  bkeep;
  logic [127:0] btuser;
  logic [2:0]   cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] KF = 32'hFFFF_FFFF;

  tuser_out_fsm #(.TUPLE_DEPTH(4), .CNT_W(3)) dut (
    .tout_aclk(clk), .tout_arst(arst),
    .tout_valid(tval), .tout_data(tdat),
    .tout_avalid(aval), .tout_aready(aready), .tout_adata(adat),
    .tout_akeep(akeep), .tout_atlast(alast),
    .tout_bvalid(bvalid), .tout_bready(bready), .tout_bdata(bdata),
    .tout_bkeep(bkeep), .tout_btlast(btlast), .tout_btuser(btuser),
    .tout_tuple_cnt(cnt), .tout_tuple_ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] dv(input logic [7:0] tag, input int i);
    return {32{tag}} ^ 256'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [255:0] d,
                       input logic [31:0] k, input logic l, input logic [127:0] u);
    chk({tag, ".bvalid"}, 256'(bvalid), 256'(v));
    chk({tag, ".bdata"},  bdata, d);
    chk({tag, ".bkeep"},  256'(bkeep), 256'(k));
    chk({tag, ".btlast"}, 256'(btlast), 256'(l));
    chk({tag, ".btuser"}, 256'(btuser), 256'(u));
  endtask

  task automatic drive_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    aval = 1'b1; adat = d; akeep = k; alast = l;
  endtask

  task automatic push_tuple(input logic [127:0] t);
    tval = 1'b1; tdat = t;
    tick();
    tval = 1'b0;
  endtask

  initial begin
    arst = 1'b0; tval = 1'b0; tdat = '0; aval = 1'b0; adat = '0;
    akeep = '0; alast = 1'b0; bready = 1'b1;

    // ---- reset state
    tick(); tick();
    #1;
    chk("rst.aready", 256'(aready), 256'(0));
    chk_b("rst", 1'b0, '0, '0, 1'b0, '0);
    chk("rst.cnt", 256'(cnt), 256'(0));
    chk("rst.ovf", 256'(ovf), 256'(0));
    arst = 1'b1;
    tick();

    // ---- 1: tuple A5 then 3-beat packet
    push_tuple(128'hA5);
    chk("t1.cnt1", 256'(cnt), 256'(1));
    drive_beat(dv(8'hD0, 0), KF, 1'b0); #1;
    chk("t1.ar0", 256'(aready), 256'(1));
    tick();
    chk_b("t1.b0", 1'b1, dv(8'hD0, 0), KF, 1'b0, 128'hA5);
    drive_beat(dv(8'hD0, 1), KF, 1'b0); #1;
    chk("t1.ar1", 256'(aready), 256'(1));
    tick();
    chk_b("t1.b1", 1'b1, dv(8'hD0, 1), KF, 1'b0, 128'hA5);
    drive_beat(dv(8'hD0, 2), 32'h0000_FFFF, 1'b1); #1;
    chk("t1.ar2", 256'(aready), 256'(1));
    tick();
    chk_b("t1.b2", 1'b1, dv(8'hD0, 2), 32'h0000_FFFF, 1'b1, 128'hA5);
    chk("t1.cnt0", 256'(cnt), 256'(0));
    aval = 1'b0;
    tick();
    chk("t1.idle", 256'(bvalid), 256'(0));

    // ---- 2: beat waits for a late tuple
    drive_beat(dv(8'hE0, 0), KF, 1'b1); #1;
    chk("t2.ar_c0", 256'(aready), 256'(0));
    tick();
    chk("t2.bv_c1", 256'(bvalid), 256'(0));
    tick();
    tick();
    tval = 1'b1; tdat = 128'h77; #1;
    chk("t2.ar_strobe", 256'(aready), 256'(0));
    tick();
    tval = 1'b0; #1;
    chk("t2.cnt", 256'(cnt), 256'(1));
    chk("t2.ar_after", 256'(aready), 256'(1));
    chk("t2.bv_pre", 256'(bvalid), 256'(0));
    tick();
    chk_b("t2.b0", 1'b1, dv(8'hE0, 0), KF, 1'b1, 128'h77);
    chk("t2.cnt0", 256'(cnt), 256'(0));
    aval = 1'b0;
    tick();

    // ---- 3: 4-beat packet with output stall
    push_tuple(128'h33);
    drive_beat(dv(8'hF0, 0), KF, 1'b0);
    tick();
    chk_b("t3.b0", 1'b1, dv(8'hF0, 0), KF, 1'b0, 128'h33);
    drive_beat(dv(8'hF0, 1), KF, 1'b0);
    tick();
    chk_b("t3.b1", 1'b1, dv(8'hF0, 1), KF, 1'b0, 128'h33);
    drive_beat(dv(8'hF0, 2), KF, 1'b0);
    bready = 1'b0; #1;
    chk("t3.ar_st0", 256'(aready), 256'(0));
    tick();
    chk_b("t3.hold0", 1'b1, dv(8'hF0, 1), KF, 1'b0, 128'h33);
    #1;
    chk("t3.ar_st1", 256'(aready), 256'(0));
    tick();
    chk_b("t3.hold1", 1'b1, dv(8'hF0, 1), KF, 1'b0, 128'h33);
    bready = 1'b1; #1;
    chk("t3.ar_go", 256'(aready), 256'(1));
    tick();
    chk_b("t3.b2", 1'b1, dv(8'hF0, 2), KF, 1'b0, 128'h33);
    drive_beat(dv(8'hF0, 3), KF, 1'b1);
    tick();
    chk_b("t3.b3", 1'b1, dv(8'hF0, 3), KF, 1'b1, 128'h33);
    aval = 1'b0;
    tick();
    chk("t3.done", 256'(bvalid), 256'(0));
    chk("t3.cnt", 256'(cnt), 256'(0));

    // ---- 4: overflow with 5 strobes, then drain in order
    for (int i = 1; i <= 5; i++) push_tuple(128'h100 + 128'(i));
    chk("t4.cnt_full", 256'(cnt), 256'(4));
    chk("t4.ovf", 256'(ovf), 256'(1));
    for (int i = 1; i <= 4; i++) begin
      drive_beat(dv(8'h60, i), KF, 1'b1);
      tick();
      chk_b("t4.pkt", 1'b1, dv(8'h60, i), KF, 1'b1, 128'h100 + 128'(i));
    end
    #1;
    chk("t4.cnt0", 256'(cnt), 256'(0));
    chk("t4.ar0", 256'(aready), 256'(0));
    chk("t4.ovf_held", 256'(ovf), 256'(1));
    aval = 1'b0;
    tick();

    // ---- 5: push while full with simultaneous pop
    arst = 1'b0;
    tick();
    chk("t5.ovf_clr", 256'(ovf), 256'(0));
    arst = 1'b1;
    for (int i = 1; i <= 4; i++) push_tuple(128'h200 + 128'(i));
    chk("t5.cnt_full", 256'(cnt), 256'(4));
    drive_beat(dv(8'h50, 1), KF, 1'b1);
    tval = 1'b1; tdat = 128'h205; #1;
    chk("t5.ar", 256'(aready), 256'(1));
    tick();
    tval = 1'b0;
    chk_b("t5.p1", 1'b1, dv(8'h50, 1), KF, 1'b1, 128'h201);
    chk("t5.cnt_same", 256'(cnt), 256'(4));
    chk("t5.ovf0", 256'(ovf), 256'(0));
    for (int i = 2; i <= 5; i++) begin
      drive_beat(dv(8'h50, i), KF, 1'b1);
      tick();
      chk_b("t5.drain", 1'b1, dv(8'h50, i), KF, 1'b1, 128'h200 + 128'(i));
    end
    aval = 1'b0;
    tick();
    chk("t5.cnt0", 256'(cnt), 256'(0));

    // ---- 6: reset mid-packet discards beats and tuples
    push_tuple(128'h66);
    push_tuple(128'h67);
    drive_beat(dv(8'h40, 0), KF, 1'b0);
    tick();
    drive_beat(dv(8'h40, 1), KF, 1'b0);
    tick();
    chk_b("t6.b1", 1'b1, dv(8'h40, 1), KF, 1'b0, 128'h66);
    drive_beat(dv(8'h40, 2), KF, 1'b0);
    arst = 1'b0; #1;
    chk("t6.ar_rst", 256'(aready), 256'(0));
    tick();
    chk_b("t6.rst", 1'b0, '0, '0, 1'b0, '0);
    chk("t6.cnt", 256'(cnt), 256'(0));
    chk("t6.ovf", 256'(ovf), 256'(0));
    arst = 1'b1; #1;
    chk("t6.ar_rel", 256'(aready), 256'(0));
    tick();
    chk("t6.nostale", 256'(bvalid), 256'(0));
    aval = 1'b0;
    push_tuple(128'h88);
    drive_beat(dv(8'h30, 0), KF, 1'b0);
    tick();
    chk_b("t6.k0", 1'b1, dv(8'h30, 0), KF, 1'b0, 128'h88);
    drive_beat(dv(8'h30, 1), 32'h0000_00FF, 1'b1);
    tick();
    chk_b("t6.k1", 1'b1, dv(8'h30, 1), 32'h0000_00FF, 1'b1, 128'h88);
    aval = 1'b0;
    tick();
    chk("t6.end_bv", 256'(bvalid), 256'(0));
    chk("t6.end_cnt", 256'(cnt), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
